// File: rtl/conc_trace_recorder.sv
// rtl/conc_trace_recorder.sv - run-length trace recorder for core outputs with valid/ready FIFO read port
module conc_trace_recorder #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      clear,
    input  logic                      nloss,
    input  logic [3:0]                nl,
    input  logic                      speaker,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      rd_valid,
    output logic [CNT_W+5:0]          rd_data,
    input  logic                      rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = CNT_W + 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic [RW-1:0]    mem_q [DEPTH];

    logic [5:0]       samp;
    logic [AW:0]      fill;
    logic             full;
    logic             pop;
    logic             push;
    logic             push_ok;
    logic [RW-1:0]    rec;

    assign samp = {nloss, nl, speaker};
    assign fill = wptr_q - rptr_q;
    assign full = (fill == (AW+1)'(DEPTH));
    assign rec  = {cnt_q, hist_q};

    // Next-state: run-length accumulation, record push with drop-on-full, FIFO pointers, clear
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        pop     = (fill != '0) && rd_ready;

        case (state_q)
            ST_CAPTURE: begin
                if (!arm) begin
                    // Closing record; the sample on this edge is intentionally ignored
                    push    = 1'b1;
                    state_d = ST_DONE;
                end else if (samp == hist_q && cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // Value change or saturated count both close the current run
                    push   = 1'b1;
                    hist_d = samp;
                    cnt_d  = CNT_W'(1);
                end
            end
            default: begin
                if (arm) begin
                    hist_d  = samp;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_CAPTURE;
                end
            end
        endcase

        // A pop on the same edge frees the slot, so a full FIFO can still accept
        push_ok = push && (!full || pop);
        if (push && !push_ok) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
        end

        wptr_d = wptr_q + (AW+1)'(push_ok);
        rptr_d = rptr_q + (AW+1)'(pop);

        if (clear) begin
            state_d = ST_IDLE;
            hist_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            wptr_d  = '0;
            rptr_d  = '0;
            push_ok = 1'b0;
        end
    end

    // State and pointer registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Record storage; contents are don't-care outside the occupied window
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= rec;
        end
    end

    assign busy     = (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);
    assign overflow = ovf_q;
    assign level    = fill;
    assign rd_valid = (fill != '0);
    assign rd_data  = rd_valid ? mem_q[rptr_q[AW-1:0]] : '0;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// tb/tb_conc_trace_recorder.sv - scoreboard bench for conc_trace_recorder with directed and random traffic
module tb_conc_trace_recorder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        nloss = 1'b0;
    logic [3:0]  nl = 4'd0;
    logic        speaker = 1'b0;
    logic        rd_ready = 1'b0;
    logic        busy, done, overflow, rd_valid;
    logic [2:0]  level;
    logic [15:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: records as a queue, run described by value + length
    logic [15:0] exp_q[$];
    int          m_state = 0;   // 0 idle, 1 capturing, 2 done
    logic [5:0]  m_h = '0;
    logic [9:0]  m_cnt = '0;
    int          m_level = 0;
    bit          m_ovf = 1'b0;

    always #5 clock = ~clock;

    conc_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .arm(arm), .clear(clear),
        .nloss(nloss), .nl(nl), .speaker(speaker),
        .busy(busy), .done(done), .overflow(overflow), .level(level),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model, advanced once per rising edge
    initial forever begin
        logic [5:0]  s;
        logic [15:0] r;
        bit          want_push;
        @(posedge clock);
        s = {nloss, nl, speaker};
        if (reset || clear) begin
            m_state = 0; m_level = 0; m_ovf = 1'b0; m_h = '0; m_cnt = '0;
            exp_q.delete();
        end else begin
            want_push = 1'b0;
            r = {m_cnt, m_h};
            if (m_state != 1) begin
                if (arm) begin m_h = s; m_cnt = 10'd1; m_state = 1; end
            end else if (!arm) begin
                want_push = 1'b1; m_state = 2;
            end else if (s == m_h && m_cnt < 10'd1023) begin
                m_cnt = m_cnt + 10'd1;
            end else begin
                want_push = 1'b1; m_h = s; m_cnt = 10'd1;
            end
            if (m_level > 0 && rd_ready) m_level--;
            if (want_push) begin
                if (m_level < DEPTH) begin
                    exp_q.push_back(r);
                    m_level++;
                end else begin
                    m_ovf = 1'b1;
                    m_state = 2;
                end
            end
        end
    end

    // Monitor: compares outputs and pops the scoreboard on each accepted record
    initial forever begin
        logic [15:0] e;
        @(negedge clock);
        check("level", 32'(level), 32'(m_level));
        check("rd_valid", 32'(rd_valid), 32'(m_level > 0));
        check("busy", 32'(busy), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got rd_data %0h expected no record", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q[0]));
                if (rd_ready && !clear && !reset) e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] alt [4];
        alt[0] = 16'h0042; alt[1] = 16'h0044; alt[2] = 16'h0042; alt[3] = 16'h0044;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        reset = 1'b0;

        // Constant sample for five edges
        nloss = 1'b1; nl = 4'd0; speaker = 1'b0; arm = 1'b1;
        repeat (5) tick();
        arm = 1'b0;
        tick();
        check("const_done", 32'(done), 1);
        check("const_level", 32'(level), 1);
        check("const_data", 32'(rd_data), 32'h0160);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check("const_drained", 32'(level), 0);

        // Alternating nl
        clear = 1'b1; tick(); clear = 1'b0;
        nloss = 1'b0; arm = 1'b1;
        nl = 4'd1; tick(); nl = 4'd2; tick(); nl = 4'd1; tick(); nl = 4'd2; tick();
        arm = 1'b0; tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("alt_data", 32'(rd_data), 32'(alt[i]));
            tick();
        end
        rd_ready = 1'b0;

        // Count saturation
        clear = 1'b1; tick(); clear = 1'b0;
        nl = 4'd0; arm = 1'b1;
        repeat (1030) tick();
        arm = 1'b0; tick();
        check("sat_level", 32'(level), 2);
        check("sat_first", 32'(rd_data), 32'hFFC0);
        rd_ready = 1'b1; tick();
        check("sat_second", 32'(rd_data), 32'h01C0);
        tick(); rd_ready = 1'b0;

        // Overflow with no consumer
        clear = 1'b1; tick(); clear = 1'b0;
        arm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            speaker = i[0];
            tick();
            if (i == 5) begin
                check("ovf5_level", 32'(level), 4);
                check("ovf5_flag", 32'(overflow), 1);
            end
        end
        check("ovf_level", 32'(level), 4);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_done", 32'(done), 1);
        check("ovf_busy", 32'(busy), 0);
        arm = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_cnt", 32'(rd_data[15:6]), 1);
            tick();
        end
        rd_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        clear = 1'b1; tick(); clear = 1'b0;
        arm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            speaker = i[0];
            tick();
        end
        check("full_level", 32'(level), 4);
        check("full_head", 32'(rd_data), 32'h0040);
        speaker = 1'b1; rd_ready = 1'b1; tick();
        check("pp_level", 32'(level), 4);
        check("pp_ovf", 32'(overflow), 0);
        check("pp_head", 32'(rd_data), 32'h0041);
        arm = 1'b0; tick();
        rd_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;

        // Reset mid-capture after three records
        arm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            speaker = i[0];
            tick();
        end
        check("pre_rst_level", 32'(level), 3);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_data", 32'(rd_data), 0);
        tick();
        arm = 1'b0; tick();
        check("rearm_level", 32'(level), 1);
        check("rearm_cnt", 32'(rd_data[15:6]), 1);
        clear = 1'b1; tick(); clear = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(15) != 0);
            if ($urandom_range(3) == 0) begin
                nloss = 1'($urandom);
                nl = 4'($urandom_range(2));
                speaker = 1'($urandom);
            end
            rd_ready = 1'($urandom);
            clear = ($urandom_range(199) == 0);
            reset = ($urandom_range(499) == 0);
            tick();
        end
        clear = 1'b0; reset = 1'b0; arm = 1'b0; rd_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        check("final_drain", 32'(level), 0);
        check("sb_leftover", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
